// File: rtl/hdmi_video_framer.sv
// Per-pixel HDMI period sequencer: delays raw video timing so every active run is
// preceded by a video preamble and a leading guard band, feeding the TMDS channel encoders.
module hdmi_video_framer #(
  parameter int PREAMBLE_LEN = 8,
  parameter int GUARD_LEN    = 2
) (
  input  logic        i_clk,
  input  logic        i_reset,
  input  logic        i_hsync,
  input  logic        i_vsync,
  input  logic        i_de,
  input  logic [23:0] i_pixel,
  output logic [1:0]  o_dtype,
  output logic [1:0]  o_ctl0,
  output logic [1:0]  o_ctl1,
  output logic [1:0]  o_ctl2,
  output logic [7:0]  o_data0,
  output logic [7:0]  o_data1,
  output logic [7:0]  o_data2,
  output logic        o_overrun,
  output logic [1:0]  o_dbg_state
);

  localparam int LOOK   = PREAMBLE_LEN + GUARD_LEN;
  localparam int MAXLEN = (PREAMBLE_LEN > GUARD_LEN) ? PREAMBLE_LEN : GUARD_LEN;
  localparam int CW     = (MAXLEN > 1) ? $clog2(MAXLEN) : 1;

  localparam logic [1:0] DT_GUARD = 2'b00;
  localparam logic [1:0] DT_CTRL  = 2'b01;
  localparam logic [1:0] DT_PIXEL = 2'b11;

  typedef enum logic [1:0] {
    ST_CTL = 2'd0,
    ST_PRE = 2'd1,
    ST_GRD = 2'd2
  } state_t;

  typedef struct packed {
    logic        hsync;
    logic        vsync;
    logic        de;
    logic [23:0] pixel;
  } slot_t;

  slot_t   sr_q [LOOK];
  slot_t   sr_d [LOOK];
  slot_t   tap;
  logic    prev_de_q, prev_de_d;
  logic    rise;
  state_t  state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;

  logic [1:0] dtype_q, dtype_d;
  logic [1:0] ctl0_q, ctl0_d;
  logic [1:0] ctl1_q, ctl1_d;
  logic [1:0] ctl2_q, ctl2_d;
  logic [7:0] data0_q, data0_d;
  logic [7:0] data1_q, data1_d;
  logic [7:0] data2_q, data2_d;
  logic       overrun_q, overrun_d;

  // The oldest stage is the sample whose slot is being computed this cycle.
  assign tap  = sr_q[LOOK-1];
  assign rise = i_de && !prev_de_q;

  always_comb begin
    sr_d[0] = '{hsync: i_hsync, vsync: i_vsync, de: i_de, pixel: i_pixel};
    for (int i = 1; i < LOOK; i++) begin
      sr_d[i] = sr_q[i-1];
    end
    prev_de_d = i_de;
  end

  // Next state; a rising edge always restarts the preamble, whatever the state.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    if (rise) begin
      state_d = ST_PRE;
      cnt_d   = CW'(PREAMBLE_LEN - 1);
    end else begin
      case (state_q)
        ST_PRE: begin
          if (cnt_q == '0) begin
            state_d = ST_GRD;
            cnt_d   = CW'(GUARD_LEN - 1);
          end else begin
            cnt_d = cnt_q - CW'(1);
          end
        end
        ST_GRD: begin
          if (cnt_q == '0) begin
            state_d = ST_CTL;
          end else begin
            cnt_d = cnt_q - CW'(1);
          end
        end
        default: begin
        end
      endcase
    end
  end

  // Slot contents follow the next state so the preamble appears the cycle after the edge.
  always_comb begin
    dtype_d   = DT_CTRL;
    ctl0_d    = {tap.vsync, tap.hsync};
    ctl1_d    = 2'b00;
    ctl2_d    = 2'b00;
    data0_d   = 8'h00;
    data1_d   = 8'h00;
    data2_d   = 8'h00;
    overrun_d = overrun_q;
    case (state_d)
      ST_PRE: begin
        ctl1_d = 2'b01;
        if (tap.de) overrun_d = 1'b1;
      end
      ST_GRD: begin
        dtype_d = DT_GUARD;
        if (tap.de) overrun_d = 1'b1;
      end
      default: begin
        if (tap.de) begin
          dtype_d = DT_PIXEL;
          data0_d = tap.pixel[7:0];
          data1_d = tap.pixel[15:8];
          data2_d = tap.pixel[23:16];
        end
      end
    endcase
  end

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      for (int i = 0; i < LOOK; i++) begin
        sr_q[i] <= '0;
      end
      prev_de_q <= 1'b0;
      state_q   <= ST_CTL;
      cnt_q     <= '0;
      dtype_q   <= DT_CTRL;
      ctl0_q    <= 2'b00;
      ctl1_q    <= 2'b00;
      ctl2_q    <= 2'b00;
      data0_q   <= 8'h00;
      data1_q   <= 8'h00;
      data2_q   <= 8'h00;
      overrun_q <= 1'b0;
    end else begin
      for (int i = 0; i < LOOK; i++) begin
        sr_q[i] <= sr_d[i];
      end
      prev_de_q <= prev_de_d;
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      dtype_q   <= dtype_d;
      ctl0_q    <= ctl0_d;
      ctl1_q    <= ctl1_d;
      ctl2_q    <= ctl2_d;
      data0_q   <= data0_d;
      data1_q   <= data1_d;
      data2_q   <= data2_d;
      overrun_q <= overrun_d;
    end
  end

  assign o_dtype     = dtype_q;
  assign o_ctl0      = ctl0_q;
  assign o_ctl1      = ctl1_q;
  assign o_ctl2      = ctl2_q;
  assign o_data0     = data0_q;
  assign o_data1     = data1_q;
  assign o_data2     = data2_q;
  assign o_overrun   = overrun_q;
  assign o_dbg_state = state_q;

endmodule
